rbf16_coef_loader: RTL and testbench

- Upstream configuration stage for the BF16 piecewise-linear register-file exp unit.
- Accepts a valid/ready stream of 32-bit coefficient words: base in [31:16], offset in [15:0].
- Sequences the words into that unit's single-entry write port: cfg_w_en, cfg_sgn, cfg_idx, cfg_base, cfg_offset.
- Raises table_valid once a full table (both signs × all exponent segments) has been written; downstream control gates exp traffic on it.

---
 rtl/rbf16_coef_loader.sv | 69 ++++++
 tb/tb_rbf16_coef_loader.sv | 137 +++++++++++++
 2 files changed

// File: rtl/rbf16_coef_loader.sv
// rbf16_coef_loader: streams 32-bit coefficient words into the BF16 exp register-file write port
module rbf16_coef_loader #(
  parameter int NUM_IDX = 13,
  parameter int IDX_W   = 4
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             start,
  input  logic             in_valid,
  input  logic [31:0]      in_data,
  output logic             in_ready,
  output logic             cfg_w_en,
  output logic             cfg_sgn,
  output logic [IDX_W-1:0] cfg_idx,
  output logic [15:0]      cfg_base,
  output logic [15:0]      cfg_offset,
  output logic             busy,
  output logic             done,
  output logic             table_valid
);
  typedef enum logic {IDLE, LOAD} state_t;
  state_t state, state_d;
  logic sgn_cnt;
  logic [IDX_W-1:0] idx_cnt;
  logic accept, take, last_idx, last;
  assign in_ready = state == LOAD;
  assign busy     = state == LOAD;
  assign accept   = in_valid & in_ready;
  assign take     = accept & ~start;
  assign last_idx = idx_cnt == IDX_W'(NUM_IDX - 1);
  assign last     = sgn_cnt & last_idx;
  always_comb begin
    state_d = start ? LOAD : (take && last) ? IDLE : state;
  end
  always_ff @(posedge clk) begin
    if (rst) begin
      state       <= IDLE;
      sgn_cnt     <= 1'b0;
      idx_cnt     <= '0;
      cfg_w_en    <= 1'b0;
      cfg_sgn     <= 1'b0;
      cfg_idx     <= '0;
      cfg_base    <= '0;
      cfg_offset  <= '0;
      done        <= 1'b0;
      table_valid <= 1'b0;
    end else begin
      state    <= state_d;
      cfg_w_en <= take;
      done     <= take & last;
      if (take) begin
        cfg_sgn    <= sgn_cnt;
        cfg_idx    <= idx_cnt;
        cfg_base   <= in_data[31:16];
        cfg_offset <= in_data[15:0];
      end
      // a restart wins over any handshake in the same cycle
      if (start) begin
        sgn_cnt     <= 1'b0;
        idx_cnt     <= '0;
        table_valid <= 1'b0;
      end else if (take) begin
        idx_cnt <= last_idx ? '0 : idx_cnt + 1'b1;
        sgn_cnt <= sgn_cnt ^ last_idx;
        if (last) table_valid <= 1'b1;
      end
    end
  end
endmodule

// File: tb/tb_rbf16_coef_loader.sv
// tb_rbf16_coef_loader: scoreboard bench for the coefficient loader write sequencing
module tb_rbf16_coef_loader;
  logic clk = 0, rst = 0, start = 0, in_valid = 0;
  logic [31:0] in_data = '0;
  logic in_ready, cfg_w_en, cfg_sgn, busy, done, table_valid;
  logic [3:0] cfg_idx;
  logic [15:0] cfg_base, cfg_offset;
  int vectors = 0, miscompares = 0, nwr = 0;

  typedef struct packed {
    logic sgn;
    logic [3:0] idx;
    logic [31:0] data;
    logic last;
  } exp_t;
  exp_t q[$];

  logic m_load = 0, m_sgn = 0, m_tv = 0;
  int m_idx = 0;

  rbf16_coef_loader dut (
    .clk(clk), .rst(rst), .start(start), .in_valid(in_valid), .in_data(in_data),
    .in_ready(in_ready), .cfg_w_en(cfg_w_en), .cfg_sgn(cfg_sgn), .cfg_idx(cfg_idx),
    .cfg_base(cfg_base), .cfg_offset(cfg_offset), .busy(busy), .done(done),
    .table_valid(table_valid)
  );

  always #5 clk = ~clk;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] req);
    vectors++;
    if (act !== req) begin
      miscompares++;
      $display("FAIL %s: got %0h expected %0h", name, act, req);
    end
  endtask

  // drive one cycle of inputs, advance the reference model across the edge, then check status
  task automatic cycle(input logic r, input logic s, input logic v, input logic [31:0] d);
    logic lst;
    rst = r; start = s; in_valid = v; in_data = d;
    if (r) begin
      m_load = 0; m_sgn = 0; m_idx = 0; m_tv = 0;
    end else if (s) begin
      m_load = 1; m_sgn = 0; m_idx = 0; m_tv = 0;
    end else if (v && m_load) begin
      lst = m_sgn && m_idx == 12;
      q.push_back('{sgn: m_sgn, idx: 4'(m_idx), data: d, last: lst});
      if (m_idx == 12) begin m_idx = 0; m_sgn = ~m_sgn; end else m_idx++;
      if (lst) begin m_load = 0; m_tv = 1; end
    end
    @(posedge clk); #1;
    chk("in_ready", in_ready, m_load);
    chk("busy", busy, m_load);
    chk("table_valid", table_valid, m_tv);
  endtask

  function automatic logic [31:0] word(input int k);
    return {16'h3F80 + 16'(k), 16'h0010 + 16'(k)};
  endfunction

  task automatic drain(input string name, input int writes);
    cycle(0, 0, 0, 0);
    cycle(0, 0, 0, 0);
    chk({name, "_pending"}, q.size(), 0);
    chk({name, "_writes"}, nwr, writes);
    nwr = 0;
  endtask

  // monitor: every write strobe must match the oldest expected write
  initial begin
    exp_t e;
    forever begin
      @(negedge clk);
      if (cfg_w_en) begin
        nwr++;
        if (q.size() == 0) begin
          chk("unexpected_write", 1, 0);
        end else begin
          e = q.pop_front();
          chk("wr_sgn", cfg_sgn, e.sgn);
          chk("wr_idx", cfg_idx, e.idx);
          chk("wr_base", cfg_base, e.data[31:16]);
          chk("wr_offset", cfg_offset, e.data[15:0]);
          chk("wr_done", done, e.last);
          chk("wr_table_valid", table_valid, e.last);
        end
      end else if (done) begin
        chk("done_without_write", 1, 0);
      end
    end
  end

  initial begin
    @(posedge clk); #1;
    cycle(1, 0, 0, 0);
    chk("rst_outputs", {cfg_w_en, cfg_sgn, cfg_idx, cfg_base, cfg_offset, done}, 0);
    for (int i = 0; i < 5; i++) cycle(0, 0, 1, 32'h3F80_0100);
    drain("idle", 0);

    cycle(0, 1, 0, 0);
    for (int k = 0; k < 26; k++) cycle(0, 0, 1, word(k));
    drain("b2b", 26);

    cycle(0, 1, 0, 0);
    for (int k = 0; k < 26; k++) begin
      cycle(0, 0, 1, word(k));
      if (k < 25) begin cycle(0, 0, 0, 0); cycle(0, 0, 0, 0); end
    end
    drain("gaps", 26);

    cycle(0, 1, 0, 0);
    for (int k = 0; k < 7; k++) cycle(0, 0, 1, word(k));
    cycle(0, 1, 1, 32'hDEAD_BEEF);
    for (int k = 0; k < 26; k++) cycle(0, 0, 1, word(40 + k));
    drain("restart", 33);

    chk("tv_before_rst", table_valid, 1);
    cycle(1, 0, 0, 0);
    chk("rst2_outputs", {cfg_w_en, cfg_sgn, cfg_idx, cfg_base, cfg_offset, done, table_valid}, 0);
    cycle(0, 1, 0, 0);
    for (int k = 0; k < 3; k++) cycle(0, 0, 1, word(k));
    cycle(1, 0, 1, word(3));
    chk("rst_abort_w_en", cfg_w_en, 0);
    drain("abort", 3);

    cycle(0, 1, 0, 0);
    for (int k = 0; k < 25; k++) cycle(0, 0, 1, word(k));
    cycle(0, 1, 1, word(25));
    chk("race_done", done, 0);
    for (int k = 0; k < 26; k++) cycle(0, 0, 1, word(60 + k));
    drain("race", 51);

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end
endmodule
